fetch_sequencer: RTL

//   Controller that drives the 8-bit program counter's load/inc pins and fetches instruction bytes.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and fetch-path constants.
package cpu_pkg;

  // Fetch sequencer states; the encoding is also visible on the debug port.
  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_FETCH_ARG = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_HALT      = 3'd4
  } fetch_state_e;

  // PC value loaded when the sequencer leaves reset.
  localparam logic [7:0] RESET_VEC   = 8'h00;
  // Opcode bit that marks a two-byte (opcode + operand) instruction.
  localparam int         LONG_OP_BIT = 7;
  // Opcode that stops fetching once it has been issued.
  localparam logic [7:0] HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC load/inc pins, reads opcode (and operand)
// bytes from instruction memory, and hands assembled instructions to the
// decoder. Branch redirects are applied in the issue handshake cycle.
//
// Handshakes:
//   memory : mem_req stays high with mem_addr = pc_in until mem_ack; the byte
//            on mem_rdata is consumed in the ack cycle. Acks arriving while no
//            fetch is outstanding are ignored.
//   decoder: instr_valid stays high with opcode/operand stable until the cycle
//            where instr_ready is also high; that cycle is the transfer, and
//            branch_req is only looked at in that cycle.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_VEC   = cpu_pkg::RESET_VEC,
  parameter int         LONG_OP_BIT = cpu_pkg::LONG_OP_BIT,
  parameter logic [7:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pc_in,
  output logic       pc_load,
  output logic [7:0] pc_load_val,
  output logic       pc_inc,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  input  logic       branch_req,
  input  logic [7:0] branch_target,
  output logic       halted,
  output logic [2:0] dbg_state
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [7:0]   r_opcode;
  logic [7:0]   r_operand;

  logic         w_pc_load;
  logic [7:0]   w_pc_load_val;
  logic         w_pc_inc;
  logic         w_mem_req;
  logic         w_instr_valid;
  logic         w_halted;
  logic         w_op_capture;
  logic         w_arg_capture;

  // State register; reset parks the FSM in BOOT so the PC is reloaded on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; PC load and increment are mutually exclusive by state.
  always_comb begin
    w_next_state  = r_state;
    w_pc_load     = 1'b0;
    w_pc_load_val = RESET_VEC;
    w_pc_inc      = 1'b0;
    w_mem_req     = 1'b0;
    w_instr_valid = 1'b0;
    w_halted      = 1'b0;
    w_op_capture  = 1'b0;
    w_arg_capture = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_pc_load    = 1'b1;
        w_next_state = ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          w_op_capture = 1'b1;
          w_pc_inc     = 1'b1;
          w_next_state = mem_rdata[LONG_OP_BIT] ? ST_FETCH_ARG : ST_ISSUE;
        end
      end
      ST_FETCH_ARG: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          w_arg_capture = 1'b1;
          w_pc_inc      = 1'b1;
          w_next_state  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_instr_valid = 1'b1;
        if (instr_ready) begin
          if (branch_req) begin
            // Redirect wins over halt: the PC is loaded now and fetch
            // resumes from the target on the next cycle.
            w_pc_load     = 1'b1;
            w_pc_load_val = branch_target;
            w_next_state  = ST_FETCH_OP;
          end else if (r_opcode == HALT_OPCODE) begin
            w_next_state = ST_HALT;
          end else begin
            w_next_state = ST_FETCH_OP;
          end
        end
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  // Opcode/operand capture; a fresh opcode clears the operand so 1-byte instructions issue 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= 8'h00;
      r_operand <= 8'h00;
    end else if (w_op_capture) begin
      r_opcode  <= mem_rdata;
      r_operand <= 8'h00;
    end else if (w_arg_capture) begin
      r_operand <= mem_rdata;
    end
  end

  // PC pulses are gated by rst_n so nothing reaches the counter while reset is held.
  assign pc_load       = w_pc_load & rst_n;
  assign pc_inc        = w_pc_inc & rst_n;
  assign pc_load_val   = w_pc_load_val;
  assign mem_req       = w_mem_req;
  assign mem_addr      = pc_in;
  assign instr_valid   = w_instr_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign halted        = w_halted;
  assign dbg_state     = r_state;

endmodule
